sbd_commit_ctrl: RTL and testbench



---
 rtl/sbd_commit_ctrl.sv | 114 +++++++++++
 tb/tb_sbd_commit_ctrl.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/sbd_commit_ctrl.sv
// In-order commit scheduler: circular scoreboard of issued instructions, retiring up to two
// of the oldest entries per cycle when their execution pipelines have results ready.
module sbd_commit_ctrl #(
  parameter int unsigned Depth = 8,
  parameter int unsigned NPl   = 5
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  input  logic                    flush_i,
  input  logic [1:0]              issue_valid_i,
  input  logic [2*NPl-1:0]        issue_pl_i,
  input  logic [63:0]             issue_pc_i,
  output logic [1:0]              issue_ready_o,
  input  logic [NPl-1:0]          pl_valid_i,
  input  logic [NPl-1:0]          pl_err_i,
  output logic [NPl-1:0]          pl_ack_o,
  output logic [1:0]              cmt_valid_o,
  output logic [2*NPl-1:0]        cmt_pl_o,
  output logic [63:0]             cmt_pc_o,
  output logic                    cmt_err_o,
  output logic [$clog2(Depth):0]  count_o
);

  localparam int unsigned PtrW = $clog2(Depth);
  localparam int unsigned CntW = PtrW + 1;

  logic [NPl-1:0]  pl_q [Depth];
  logic [31:0]     pc_q [Depth];
  logic [PtrW-1:0] rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
  logic [CntW-1:0] count_q, count_d;

  logic [PtrW-1:0] head1_idx, wr1_idx;
  logic [NPl-1:0]  head0_pl, head1_pl;
  logic [CntW-1:0] free;
  logic            push0, push1, pop0, pop1, err0;
  logic [1:0]      n_push, n_pop;

  assign head1_idx = rd_ptr_q + PtrW'(1);
  assign wr1_idx   = wr_ptr_q + PtrW'(1);
  assign head0_pl  = pl_q[rd_ptr_q];
  assign head1_pl  = pl_q[head1_idx];
  assign count_o   = count_q;

  always_comb begin
    free = CntW'(Depth) - count_q;
    if (free >= CntW'(2)) begin
      issue_ready_o = 2'b11;
    end else if (free == CntW'(1)) begin
      issue_ready_o = 2'b01;
    end else begin
      issue_ready_o = 2'b00;
    end

    // Slot1 is only ever accepted alongside slot0, keeping pushes contiguous.
    push0 = ~flush_i & issue_valid_i[0] & issue_ready_o[0];
    push1 = push0 & issue_valid_i[1] & issue_ready_o[1];

    pop0 = ~flush_i & (count_q != '0) & (|(pl_valid_i & head0_pl));
    err0 = pop0 & (|(pl_err_i & head0_pl));
    // An excepting head0 stops the bundle; a shared pipeline yields one result per cycle.
    pop1 = pop0 & ~err0 & (count_q >= CntW'(2)) & (|(pl_valid_i & head1_pl)) &
           (head1_pl != head0_pl);

    n_push = {1'b0, push0} + {1'b0, push1};
    n_pop  = {1'b0, pop0} + {1'b0, pop1};

    cmt_valid_o = {pop1, pop0};
    cmt_err_o   = err0;
    cmt_pl_o    = {head1_pl, head0_pl};
    cmt_pc_o    = {pc_q[head1_idx], pc_q[rd_ptr_q]};
    pl_ack_o    = (pop0 ? head0_pl : '0) | (pop1 ? head1_pl : '0);

    if (flush_i) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
    end else begin
      rd_ptr_d = rd_ptr_q + PtrW'(n_pop);
      wr_ptr_d = wr_ptr_q + PtrW'(n_push);
      count_d  = count_q + CntW'(n_push) - CntW'(n_pop);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < int'(Depth); i++) begin
        pl_q[i] <= '0;
        pc_q[i] <= '0;
      end
    end else begin
      if (push0) begin
        pl_q[wr_ptr_q] <= issue_pl_i[NPl-1:0];
        pc_q[wr_ptr_q] <= issue_pc_i[31:0];
      end
      if (push1) begin
        pl_q[wr1_idx] <= issue_pl_i[2*NPl-1:NPl];
        pc_q[wr1_idx] <= issue_pc_i[63:32];
      end
    end
  end

endmodule

// File: tb/tb_sbd_commit_ctrl.sv
// Directed bench for sbd_commit_ctrl plus a short queue-model wrap-around run.
module tb_sbd_commit_ctrl;

  logic        clk_i = 1'b0;
  logic        rst_ni;
  logic        flush_i;
  logic [1:0]  issue_valid_i;
  logic [9:0]  issue_pl_i;
  logic [63:0] issue_pc_i;
  logic [1:0]  issue_ready_o;
  logic [4:0]  pl_valid_i;
  logic [4:0]  pl_err_i;
  logic [4:0]  pl_ack_o;
  logic [1:0]  cmt_valid_o;
  logic [9:0]  cmt_pl_o;
  logic [63:0] cmt_pc_o;
  logic        cmt_err_o;
  logic [3:0]  count_o;

  int n_cmp = 0;
  int n_err = 0;

  typedef struct {
    logic [4:0]  pl;
    logic [31:0] pc;
  } ent_t;
  ent_t q[$];

  sbd_commit_ctrl #(.Depth(8), .NPl(5)) dut (
    .clk_i         (clk_i),
    .rst_ni        (rst_ni),
    .flush_i       (flush_i),
    .issue_valid_i (issue_valid_i),
    .issue_pl_i    (issue_pl_i),
    .issue_pc_i    (issue_pc_i),
    .issue_ready_o (issue_ready_o),
    .pl_valid_i    (pl_valid_i),
    .pl_err_i      (pl_err_i),
    .pl_ack_o      (pl_ack_o),
    .cmt_valid_o   (cmt_valid_o),
    .cmt_pl_o      (cmt_pl_o),
    .cmt_pc_o      (cmt_pc_o),
    .cmt_err_o     (cmt_err_o),
    .count_o       (count_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic [1:0] iv, input logic [4:0] p1, input logic [4:0] p0,
                       input logic [31:0] pc1, input logic [31:0] pc0,
                       input logic [4:0] pv, input logic [4:0] pe, input logic fl);
    issue_valid_i = iv;
    issue_pl_i    = {p1, p0};
    issue_pc_i    = {pc1, pc0};
    pl_valid_i    = pv;
    pl_err_i      = pe;
    flush_i       = fl;
  endtask

  // Illegal-stimulus guard: accepted slots must carry a one-hot pipeline tag.
  always @(posedge clk_i) begin
    if (rst_ni && !flush_i) begin
      if (issue_valid_i[0] && issue_ready_o[0] && !$onehot(issue_pl_i[4:0])) begin
        n_err++;
        $error("FAIL onehot_slot0 observed=%0h expected=onehot", issue_pl_i[4:0]);
      end
      if (issue_valid_i == 2'b11 && issue_ready_o[1] && !$onehot(issue_pl_i[9:5])) begin
        n_err++;
        $error("FAIL onehot_slot1 observed=%0h expected=onehot", issue_pl_i[9:5]);
      end
    end
  end

  initial begin
    logic [1:0]  iv;
    logic [4:0]  p0, p1, pv, exp_ack;
    logic [31:0] pc_n;
    int          free;
    logic        e0, e1, a0, a1;

    rst_ni = 1'b0;
    drive(2'b00, '0, '0, '0, '0, '0, '0, 1'b0);
    #12;
    chk("rst_count", count_o, 0);
    chk("rst_ready", issue_ready_o, 2'b11);
    chk("rst_cmt_valid", cmt_valid_o, 0);
    chk("rst_ack", pl_ack_o, 0);
    chk("rst_err", cmt_err_o, 0);
    chk("rst_cmt_pc", cmt_pc_o, 0);
    chk("rst_cmt_pl", cmt_pl_o, 0);
    @(negedge clk_i);
    rst_ni = 1'b1;

    // Dual push then dual commit on distinct pipelines.
    drive(2'b11, 5'b00100, 5'b00010, 32'h104, 32'h100, '0, '0, 1'b0);
    #1 chk("t1_empty_no_commit", cmt_valid_o, 0);
    @(negedge clk_i);
    drive(2'b00, '0, '0, '0, '0, 5'b00110, '0, 1'b0);
    #1;
    chk("t1_count2", count_o, 2);
    chk("t1_valid", cmt_valid_o, 2'b11);
    chk("t1_pc", cmt_pc_o, {32'h104, 32'h100});
    chk("t1_pl", cmt_pl_o, {5'b00100, 5'b00010});
    chk("t1_ack", pl_ack_o, 5'b00110);
    @(negedge clk_i);
    drive(2'b00, '0, '0, '0, '0, '0, '0, 1'b0);
    #1 chk("t1_count0", count_o, 0);

    // Same pipeline twice: one commit per cycle.
    @(negedge clk_i);
    drive(2'b11, 5'b00010, 5'b00010, 32'h204, 32'h200, '0, '0, 1'b0);
    @(negedge clk_i);
    drive(2'b00, '0, '0, '0, '0, 5'b00010, '0, 1'b0);
    #1;
    chk("t2_valid_a", cmt_valid_o, 2'b01);
    chk("t2_pc_a", cmt_pc_o[31:0], 32'h200);
    chk("t2_ack_a", pl_ack_o, 5'b00010);
    @(negedge clk_i);
    #1;
    chk("t2_count1", count_o, 1);
    chk("t2_valid_b", cmt_valid_o, 2'b01);
    chk("t2_pc_b", cmt_pc_o[31:0], 32'h204);
    chk("t2_ack_b", pl_ack_o, 5'b00010);
    @(negedge clk_i);
    drive(2'b00, '0, '0, '0, '0, '0, '0, 1'b0);
    #1 chk("t2_count0", count_o, 0);

    // Fill to full, pop one with issue held: no push while full, then ready=01.
    for (int k = 0; k < 4; k++) begin
      @(negedge clk_i);
      drive(2'b11, 5'b01000, 5'b00001, 32'h304 + 8 * k, 32'h300 + 8 * k, '0, '0, 1'b0);
    end
    @(negedge clk_i);
    drive(2'b11, 5'b00010, 5'b00010, 32'h3F4, 32'h3F0, 5'b00001, '0, 1'b0);
    #1;
    chk("t3_full_count", count_o, 8);
    chk("t3_full_ready", issue_ready_o, 2'b00);
    chk("t3_pop_valid", cmt_valid_o, 2'b01);
    chk("t3_pop_pc", cmt_pc_o[31:0], 32'h300);
    @(negedge clk_i);
    drive(2'b11, 5'b00010, 5'b00010, 32'h324, 32'h320, '0, '0, 1'b0);
    #1;
    chk("t3_count7", count_o, 7);
    chk("t3_ready01", issue_ready_o, 2'b01);
    @(negedge clk_i);
    drive(2'b00, '0, '0, '0, '0, 5'b11111, '0, 1'b0);
    #1;
    chk("t3_refull_count", count_o, 8);
    chk("t3_drain_pc", cmt_pc_o, {32'h308, 32'h304});
    for (int k = 0; k < 4; k++) begin
      chk("t3_drain_valid", cmt_valid_o, 2'b11);
      @(negedge clk_i);
      #1;
    end
    chk("t3_drained", count_o, 0);

    // Exception on head0 blocks head1; head1 commits the next cycle.
    drive(2'b11, 5'b00010, 5'b00100, 32'h404, 32'h400, '0, '0, 1'b0);
    @(negedge clk_i);
    drive(2'b00, '0, '0, '0, '0, 5'b00110, 5'b00100, 1'b0);
    #1;
    chk("t4_valid", cmt_valid_o, 2'b01);
    chk("t4_err", cmt_err_o, 1'b1);
    chk("t4_ack", pl_ack_o, 5'b00100);
    chk("t4_pc", cmt_pc_o[31:0], 32'h400);
    @(negedge clk_i);
    drive(2'b00, '0, '0, '0, '0, 5'b00010, '0, 1'b0);
    #1;
    chk("t4_next_valid", cmt_valid_o, 2'b01);
    chk("t4_next_pc", cmt_pc_o[31:0], 32'h404);
    chk("t4_next_err", cmt_err_o, 1'b0);
    @(negedge clk_i);
    drive(2'b00, '0, '0, '0, '0, '0, '0, 1'b0);
    #1 chk("t4_count0", count_o, 0);

    // Flush with six entries, all pipelines valid and issue requested.
    for (int k = 0; k < 3; k++) begin
      @(negedge clk_i);
      drive(2'b11, 5'b00010, 5'b00001, 32'h504 + 8 * k, 32'h500 + 8 * k, '0, '0, 1'b0);
    end
    @(negedge clk_i);
    drive(2'b11, 5'b00010, 5'b00001, 32'h604, 32'h600, 5'b11111, 5'b11111, 1'b1);
    #1;
    chk("t5_count6", count_o, 6);
    chk("t5_valid", cmt_valid_o, 0);
    chk("t5_ack", pl_ack_o, 0);
    chk("t5_err", cmt_err_o, 0);
    @(negedge clk_i);
    drive(2'b00, '0, '0, '0, '0, '0, '0, 1'b0);
    #1;
    chk("t5_count0", count_o, 0);
    chk("t5_ready", issue_ready_o, 2'b11);

    // Random push/pop across the pointer wrap, checked against a queue model.
    pc_n = 32'h1000;
    for (int k = 0; k < 24; k++) begin
      @(negedge clk_i);
      chk("rnd_count", count_o, q.size());
      iv = 2'($urandom_range(0, 3));
      p0 = 5'b00001 << $urandom_range(0, 2);
      p1 = 5'b00001 << $urandom_range(0, 2);
      pv = 5'($urandom_range(0, 7));
      drive(iv, p1, p0, pc_n + 32'h4, pc_n, pv, '0, 1'b0);
      #1;
      free = 8 - q.size();
      chk("rnd_ready", issue_ready_o, (free >= 2) ? 2'b11 : (free == 1) ? 2'b01 : 2'b00);
      e0 = (q.size() >= 1) && ((pv & q[0].pl) != 0);
      e1 = e0 && (q.size() >= 2) && ((pv & q[1].pl) != 0) && (q[1].pl != q[0].pl);
      chk("rnd_valid", cmt_valid_o, {e1, e0});
      exp_ack = '0;
      if (e0) begin
        chk("rnd_pc0", cmt_pc_o[31:0], q[0].pc);
        exp_ack = q[0].pl;
      end
      if (e1) begin
        chk("rnd_pc1", cmt_pc_o[63:32], q[1].pc);
        exp_ack = exp_ack | q[1].pl;
      end
      chk("rnd_ack", pl_ack_o, exp_ack);
      if (e0) void'(q.pop_front());
      if (e1) void'(q.pop_front());
      a0 = iv[0] && (free >= 1);
      a1 = a0 && iv[1] && (free >= 2);
      if (a0) begin
        q.push_back('{pl: p0, pc: pc_n});
        pc_n = pc_n + 32'h4;
      end
      if (a1) begin
        q.push_back('{pl: p1, pc: pc_n});
        pc_n = pc_n + 32'h4;
      end
    end

    // Asynchronous reset mid-cycle with entries present.
    @(negedge clk_i);
    drive(2'b01, '0, 5'b00001, '0, 32'h900, '0, '0, 1'b0);
    @(negedge clk_i);
    drive(2'b00, '0, '0, '0, '0, 5'b11111, '0, 1'b0);
    #2 rst_ni = 1'b0;
    #1;
    chk("arst_count", count_o, 0);
    chk("arst_valid", cmt_valid_o, 0);
    chk("arst_ready", issue_ready_o, 2'b11);
    chk("arst_pc", cmt_pc_o, 0);
    @(negedge clk_i);
    rst_ni = 1'b1;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
